alu_pipe: RTL and testbench

//   Parametrised, registered ALU with valid/ready handshake on input and output.

---
 rtl/alu_pipe_if.sv | 28 ++
 rtl/alu_pipe.sv | 134 +++++++++++++
 tb/tb_alu_pipe.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - issue/consume handshake bundle for alu_pipe
interface alu_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             c;
  logic             n;
  logic             z;
  logic             v;
  logic             busy;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, c, n, z, v, busy
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, c, n, z, v, busy
  );
endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered ALU with valid/ready handshake and iterative multiply
module alu_pipe #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input logic       clk,
  input logic       reset,
  alu_pipe_if.slave bus
);
  localparam int M  = WIDTH - 1;
  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state;
  logic [SW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] res_q;
  logic             c_q, n_q, z_q, v_q;
  logic             ov_q;
  logic             busy_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             in_fire;
  logic             is_mul;

  assign is_mul       = MUL_EN && (bus.op == 3'b111);
  assign bus.in_ready = (state == IDLE) && (!ov_q || bus.out_ready);
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign acc_next     = acc + (mplier[0] ? mcand : '0);

  assign bus.out_valid = ov_q;
  assign bus.result    = res_q;
  assign bus.c         = c_q;
  assign bus.n         = n_q;
  assign bus.z         = z_q;
  assign bus.v         = v_q;
  assign bus.busy      = busy_q;

  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.op)
      3'b000: begin
        sum     = {1'b0, bus.a} + {1'b0, bus.b};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.a[M] == bus.b[M]) && (alu_res[M] != bus.a[M]);
      end
      3'b001: begin
        // subtract as a + ~b + 1 so carry reads as "no borrow"
        sum     = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.a[M] != bus.b[M]) && (alu_res[M] != bus.a[M]);
      end
      3'b010:  alu_res = bus.a & bus.b;
      3'b011:  alu_res = bus.a | bus.b;
      3'b100:  alu_res = bus.a ^ bus.b;
      3'b101:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      3'b110:  alu_res = bus.a << bus.b[SW-1:0];
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      res_q  <= '0;
      c_q    <= 1'b0;
      n_q    <= 1'b0;
      z_q    <= 1'b0;
      v_q    <= 1'b0;
      ov_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            if (is_mul) begin
              mcand  <= bus.a;
              mplier <= bus.b;
              acc    <= '0;
              cnt    <= '0;
              busy_q <= 1'b1;
              ov_q   <= 1'b0;
              state  <= MUL;
            end else begin
              res_q <= alu_res;
              c_q   <= alu_c;
              n_q   <= alu_res[M];
              z_q   <= (alu_res == '0);
              v_q   <= alu_v;
              ov_q  <= 1'b1;
            end
          end else if (ov_q && bus.out_ready) begin
            ov_q <= 1'b0;
          end
        end
        MUL: begin
          // one multiplier bit per cycle, LSB first
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            res_q  <= acc_next;
            c_q    <= 1'b0;
            n_q    <= acc_next[M];
            z_q    <= (acc_next == '0);
            v_q    <= 1'b0;
            ov_q   <= 1'b1;
            busy_q <= 1'b0;
            cnt    <= '0;
            state  <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed vectors with a transaction-level reference model for alu_pipe
module tb_alu_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(32)) bus32 ();
  alu_pipe_if #(.WIDTH(8))  bus8 ();

  alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  alu_pipe #(.WIDTH(8),  .MUL_EN(1'b1)) dut8  (.clk(clk), .reset(reset), .bus(bus8));

  int checks = 0;
  int errors = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [63:0] res;
    logic        c, n, z, v, mul;
    longint      due;
  } ent_t;

  ent_t pend [2];
  bit   has  [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outcome of one operation, from plain modular arithmetic.
  function automatic ent_t model(input logic [63:0] a_in, input logic [63:0] b_in, input int op, input int w);
    logic [63:0] mask, a, b, full;
    longint sa, sb;
    ent_t e;
    e    = '0;
    mask = (64'd1 << w) - 1;
    a    = a_in & mask;
    b    = b_in & mask;
    case (op)
      0: begin
        full  = a + b;
        e.res = full & mask;
        e.c   = full[w];
        e.v   = (a[w-1] == b[w-1]) && (e.res[w-1] != a[w-1]);
      end
      1: begin
        full  = a + (~b & mask) + 1;
        e.res = full & mask;
        e.c   = full[w];
        e.v   = (a[w-1] != b[w-1]) && (e.res[w-1] != a[w-1]);
      end
      2: e.res = a & b;
      3: e.res = a | b;
      4: e.res = a ^ b;
      5: begin
        sa    = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb    = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        e.res = (sa < sb) ? 64'd1 : 64'd0;
      end
      6: e.res = (a << (b % w)) & mask;
      default: begin
        e.res = (a * b) & mask;
        e.mul = 1'b1;
      end
    endcase
    e.n = e.res[w-1];
    e.z = (e.res == 0);
    return e;
  endfunction

  task automatic step(input int i, input bit rst, input bit iv, input logic ir, input logic ov,
                      input bit ordy, input logic [63:0] res, input logic [3:0] flags, input logic bsy,
                      input logic [63:0] a, input logic [63:0] b, input int op, input int w);
    bit ov_e, busy_e, ir_e;
    string t;
    t = (i == 0) ? "w32" : "w8";
    if (rst) begin
      has[i] = 1'b0;
      chk({t, " reset out_valid"}, 64'(ov), 64'd0);
      chk({t, " reset result"}, res, 64'd0);
      chk({t, " reset flags"}, 64'(flags), 64'd0);
      chk({t, " reset busy"}, 64'(bsy), 64'd0);
      return;
    end
    ov_e   = has[i] && (cyc >= pend[i].due);
    busy_e = has[i] && pend[i].mul && (cyc < pend[i].due);
    ir_e   = !busy_e && (!ov_e || ordy);
    chk({t, " out_valid"}, 64'(ov), 64'(ov_e));
    chk({t, " busy"}, 64'(bsy), 64'(busy_e));
    chk({t, " in_ready"}, 64'(ir), 64'(ir_e));
    if (ov_e) begin
      chk({t, " result"}, res, pend[i].res);
      chk({t, " flags cnzv"}, 64'(flags), 64'({pend[i].c, pend[i].n, pend[i].z, pend[i].v}));
      if (ordy) has[i] = 1'b0;
    end
    if (iv && ir_e) begin
      pend[i]     = model(a, b, op, w);
      pend[i].due = cyc + 1 + (pend[i].mul ? w : 0);
      has[i]      = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    step(0, reset, bus32.in_valid, bus32.in_ready, bus32.out_valid, bus32.out_ready, 64'(bus32.result),
         {bus32.c, bus32.n, bus32.z, bus32.v}, bus32.busy, 64'(bus32.a), 64'(bus32.b), int'(bus32.op), 32);
    step(1, reset, bus8.in_valid, bus8.in_ready, bus8.out_valid, bus8.out_ready, 64'(bus8.result),
         {bus8.c, bus8.n, bus8.z, bus8.v}, bus8.busy, 64'(bus8.a), 64'(bus8.b), int'(bus8.op), 8);
  end

  task automatic drive(input int i, input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
    if (i == 0) begin
      bus32.a = a[31:0]; bus32.b = b[31:0]; bus32.op = op; bus32.in_valid = 1'b1;
    end else begin
      bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.op = op; bus8.in_valid = 1'b1;
    end
  endtask

  task automatic wait_accept(input int i);
    int n;
    logic ir;
    n = 0;
    forever begin
      @(negedge clk);
      ir = (i == 0) ? bus32.in_ready : bus8.in_ready;
      if (ir === 1'b1) break;
      n++;
      if (n > 200) begin
        chk("accept timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (i == 0) bus32.in_valid = 1'b0;
    else        bus8.in_valid  = 1'b0;
  endtask

  task automatic issue(input int i, input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
    drive(i, a, b, op);
    wait_accept(i);
  endtask

  typedef struct packed { logic [31:0] a; logic [31:0] b; logic [2:0] op; } vec_t;
  localparam int NV = 11;
  vec_t vecs [NV];
  longint t0;

  initial begin
    vecs[0]  = '{32'hF0F0F0F0, 32'hFF00FF00, 3'd2};
    vecs[1]  = '{32'hF0F0F0F0, 32'h0F0F0001, 3'd3};
    vecs[2]  = '{32'hAAAA5555, 32'hAAAA5555, 3'd4};
    vecs[3]  = '{32'h00000001, 32'd37,       3'd6};
    vecs[4]  = '{32'h80000001, 32'd1,        3'd6};
    vecs[5]  = '{32'h7FFFFFFF, 32'd1,        3'd0};
    vecs[6]  = '{32'h00000005, 32'd5,        3'd1};
    vecs[7]  = '{32'h00000003, 32'd5,        3'd1};
    vecs[8]  = '{32'h00000001, 32'hFFFFFFFF, 3'd5};
    vecs[9]  = '{32'h00000005, 32'd7,        3'd5};
    vecs[10] = '{32'h12345678, 32'h0000FFFF, 3'd0};

    bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.op = '0; bus32.out_ready = 1'b1;
    bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.op  = '0; bus8.out_ready  = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("post-reset in_ready", 64'(bus32.in_ready), 64'd1);

    // ADD wraps to zero with carry
    issue(0, 32'hFFFFFFFF, 32'h00000001, 3'd0);
    @(negedge clk);
    chk("add out_valid", 64'(bus32.out_valid), 64'd1);
    chk("add result", 64'(bus32.result), 64'h0);
    chk("add cnzv", 64'({bus32.c, bus32.n, bus32.z, bus32.v}), 64'b1010);
    @(posedge clk); #1;

    issue(0, 32'h80000000, 32'h00000001, 3'd1);
    @(negedge clk);
    chk("sub result", 64'(bus32.result), 64'h7FFFFFFF);
    chk("sub cnzv", 64'({bus32.c, bus32.n, bus32.z, bus32.v}), 64'b1001);
    @(posedge clk); #1;

    issue(0, 32'hFFFFFFFF, 32'h00000001, 3'd5);
    @(negedge clk);
    chk("slt result", 64'(bus32.result), 64'h1);
    chk("slt cnzv", 64'({bus32.c, bus32.n, bus32.z, bus32.v}), 64'b0000);
    @(posedge clk); #1;

    // back-to-back single-cycle ops must go at one per clock
    t0 = cyc;
    for (int k = 0; k < NV; k++) issue(0, 64'(vecs[k].a), 64'(vecs[k].b), vecs[k].op);
    chk("full rate cycles", 64'(cyc - t0), 64'(NV));
    @(posedge clk); #1;

    issue(0, 32'h00010003, 32'h00000005, 3'd7);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk("mul busy", 64'(bus32.busy), 64'd1);
      chk("mul in_ready", 64'(bus32.in_ready), 64'd0);
      chk("mul early out_valid", 64'(bus32.out_valid), 64'd0);
    end
    @(negedge clk);
    chk("mul out_valid", 64'(bus32.out_valid), 64'd1);
    chk("mul result", 64'(bus32.result), 64'h0005000F);
    chk("mul busy done", 64'(bus32.busy), 64'd0);
    @(posedge clk); #1;

    issue(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd7);
    repeat (34) @(posedge clk);
    #1;

    // backpressure: result held, next op waits for out_ready
    bus32.out_ready = 1'b0;
    issue(0, 32'h00000010, 32'h00000020, 3'd0);
    drive(0, 32'h0000000F, 32'h000000F0, 3'd4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold in_ready", 64'(bus32.in_ready), 64'd0);
      chk("hold out_valid", 64'(bus32.out_valid), 64'd1);
      chk("hold result", 64'(bus32.result), 64'h30);
    end
    @(posedge clk); #1;
    bus32.out_ready = 1'b1;
    wait_accept(0);
    @(negedge clk);
    chk("replace out_valid", 64'(bus32.out_valid), 64'd1);
    chk("replace result", 64'(bus32.result), 64'hFF);
    @(posedge clk); #1;

    // reset in the middle of a multiply discards it
    issue(0, 32'h00001234, 32'h00005678, 3'd7);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("async reset out_valid", 64'(bus32.out_valid), 64'd0);
    chk("async reset result", 64'(bus32.result), 64'd0);
    chk("async reset busy", 64'(bus32.busy), 64'd0);
    chk("async reset cnzv", 64'({bus32.c, bus32.n, bus32.z, bus32.v}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(negedge clk);
    @(posedge clk); #1;
    issue(0, 32'd2, 32'd3, 3'd0);
    @(negedge clk);
    chk("post-reset add", 64'(bus32.result), 64'd5);
    @(posedge clk); #1;

    // 8-bit instance
    issue(1, 8'h7F, 8'h01, 3'd0);
    @(negedge clk);
    chk("w8 add result", 64'(bus8.result), 64'h80);
    chk("w8 add cnzv", 64'({bus8.c, bus8.n, bus8.z, bus8.v}), 64'b0101);
    @(posedge clk); #1;

    issue(1, 8'h0F, 8'h11, 3'd7);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("w8 mul busy", 64'(bus8.busy), 64'd1);
      chk("w8 mul early out_valid", 64'(bus8.out_valid), 64'd0);
    end
    @(negedge clk);
    chk("w8 mul out_valid", 64'(bus8.out_valid), 64'd1);
    chk("w8 mul result", 64'(bus8.result), 64'hFF);
    @(posedge clk); #1;

    issue(1, 8'h00, 8'h01, 3'd1);
    issue(1, 8'h81, 8'd9, 3'd6);
    repeat (3) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
